// File: rtl/mem_sequencer.sv
// Bus-master sequencer that turns byte/word read/write requests into MAR-load and
// byte-transfer cycles; define MEM_SEQ_BIG_ENDIAN_EN for big-endian word accesses.
module mem_sequencer #(
  parameter logic [15:0] BUS_IDLE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        word,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [15:0] rdata,
  output logic [15:0] bus_out,
  output logic        mar_write_en,
  output logic        mem_write_en,
  input  logic [7:0]  mem_out,
  output logic [2:0]  dbg_state
);

  // Handshake: req is a level sampled only in IDLE and accepted on that edge
  // (no backpressure, no queueing); ack is a one-cycle pulse in DONE with rdata valid.

`ifdef MEM_SEQ_BIG_ENDIAN_EN
  localparam bit BIG_ENDIAN = 1'b1;
`else
  localparam bit BIG_ENDIAN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MAR_LO  = 3'd1,
    XFER_LO = 3'd2,
    MAR_HI  = 3'd3,
    XFER_HI = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state;
  logic        we_q;
  logic        word_q;
  logic [15:0] addr_q;
  logic [7:0]  byte_lo;   // byte destined for addr
  logic [7:0]  byte_hi;   // byte destined for addr+1
  logic [7:0]  rd_lo;     // byte read from addr
  logic        mar_q;
  logic        wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      ack     <= 1'b0;
      rdata   <= 16'h0000;
      bus_out <= BUS_IDLE;
      mar_q   <= 1'b0;
      wr_q    <= 1'b0;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= 16'h0000;
      byte_lo <= 8'h00;
      byte_hi <= 8'h00;
      rd_lo   <= 8'h00;
    end else begin
      ack     <= 1'b0;
      mar_q   <= 1'b0;
      wr_q    <= 1'b0;
      bus_out <= BUS_IDLE;
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            word_q  <= word;
            addr_q  <= addr;
            // Only word accesses are affected by byte order
            byte_lo <= (BIG_ENDIAN && word) ? wdata[15:8] : wdata[7:0];
            byte_hi <= BIG_ENDIAN ? wdata[7:0] : wdata[15:8];
            bus_out <= addr;
            mar_q   <= 1'b1;
            busy    <= 1'b1;
            state   <= MAR_LO;
          end
        end
        MAR_LO: begin
          if (we_q) begin
            bus_out <= {8'h00, byte_lo};
            wr_q    <= 1'b1;
          end
          state <= XFER_LO;
        end
        XFER_LO: begin
          if (!we_q) rd_lo <= mem_out;
          if (word_q) begin
            bus_out <= addr_q + 16'd1;
            mar_q   <= 1'b1;
            state   <= MAR_HI;
          end else begin
            if (!we_q) rdata <= {8'h00, mem_out};
            ack   <= 1'b1;
            state <= DONE;
          end
        end
        MAR_HI: begin
          if (we_q) begin
            bus_out <= {8'h00, byte_hi};
            wr_q    <= 1'b1;
          end
          state <= XFER_HI;
        end
        XFER_HI: begin
          if (!we_q) rdata <= BIG_ENDIAN ? {rd_lo, mem_out} : {mem_out, rd_lo};
          ack   <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are gated by rst so a reset edge can never commit a write
  assign mar_write_en = mar_q & ~rst;
  assign mem_write_en = wr_q & ~rst;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: byte-wide memory device, reference byte map,
// directed and randomized transactions with an expected-read queue.
module tb_mem_sequencer;

  localparam logic [15:0] BUS_IDLE = 16'hA5C3;
`ifdef MEM_SEQ_BIG_ENDIAN_EN
  localparam bit BIG = 1'b1;
`else
  localparam bit BIG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, we, word;
  logic [15:0] addr, wdata;
  logic        busy, ack, mar_write_en, mem_write_en;
  logic [15:0] rdata, bus_out;
  logic [7:0]  mem_out;
  logic [2:0]  dbg_state;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  ref_mem [logic [15:0]];

  // ---- clock / reset ----
  always #5 clk = ~clk;

  mem_sequencer #(.BUS_IDLE(BUS_IDLE)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .word(word), .addr(addr),
    .wdata(wdata), .busy(busy), .ack(ack), .rdata(rdata), .bus_out(bus_out),
    .mar_write_en(mar_write_en), .mem_write_en(mem_write_en),
    .mem_out(mem_out), .dbg_state(dbg_state)
  );

  // ---- memory device: MAR register, byte array, combinational read ----
  logic [7:0]  mem [0:65535];
  logic [15:0] mar = 16'h0000;
  always @(posedge clk) begin
    if (mar_write_en) mar <= bus_out;
    if (mem_write_en) mem[mar] <= bus_out[7:0];
  end
  assign mem_out = mem[mar];

  // ---- checking ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Byte that a write of d lands at addr+k
  function automatic logic [7:0] lane(input logic [15:0] d, input logic w, input int k);
    if (!w) return d[7:0];
    if (BIG) return (k == 0) ? d[15:8] : d[7:0];
    return (k == 0) ? d[7:0] : d[15:8];
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a, input logic w);
    logic [15:0] a1;
    logic [7:0]  b0, b1;
    a1 = a + 16'd1;
    b0 = ref_mem[a];
    if (!w) return {8'h00, b0};
    b1 = ref_mem[a1];
    return BIG ? {b0, b1} : {b1, b0};
  endfunction

  // ---- driver: one transaction from IDLE, checked cycle by cycle ----
  task automatic run_txn(input logic t_we, input logic t_word,
                         input logic [15:0] t_addr, input logic [15:0] t_wdata);
    int lat;
    logic [15:0] a_hi;
    logic is_mar, is_wr;
    lat  = t_word ? 5 : 3;
    a_hi = t_addr + 16'd1;
    if (!t_we) exp_q.push_back(ref_read(t_addr, t_word));
    req = 1'b1; we = t_we; word = t_word; addr = t_addr; wdata = t_wdata;
    @(posedge clk);
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req = 1'b0; addr = 16'($urandom); wdata = 16'($urandom); we = ~t_we;
      end
      check("ack", ack, n == lat);
      check("busy", busy, n <= lat);
      is_mar = (n == 1) || (t_word && n == 3);
      is_wr  = t_we && ((n == 2) || (t_word && n == 4));
      check("mar_write_en", mar_write_en, is_mar);
      check("mem_write_en", mem_write_en, is_wr);
      if (is_mar) check("bus_mar", bus_out, (n == 1) ? t_addr : a_hi);
      else if (is_wr) check("bus_wdata", bus_out, {8'h00, lane(t_wdata, t_word, (n == 2) ? 0 : 1)});
      else check("bus_idle", bus_out, BUS_IDLE);
      if (n == lat && !t_we) check("rdata", rdata, exp_q.pop_front());
    end
    if (t_we) begin
      ref_mem[t_addr] = lane(t_wdata, t_word, 0);
      check("mem_lo", mem[t_addr], ref_mem[t_addr]);
      if (t_word) begin
        ref_mem[a_hi] = lane(t_wdata, t_word, 1);
        check("mem_hi", mem[a_hi], ref_mem[a_hi]);
      end
    end
  endtask

  // ---- stimulus ----
  initial begin
    int last_ack, n_ack;
    logic [7:0] old_hi;
    rst = 1'b1; req = 1'b0; we = 1'b0; word = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_bus", bus_out, BUS_IDLE);
    check("rst_mar_we", mar_write_en, 1'b0);
    check("rst_mem_we", mem_write_en, 1'b0);
    rst = 1'b0;

    // byte write then read, neighbour untouched
    run_txn(1'b1, 1'b0, 16'h0101, 16'h77C3);
    run_txn(1'b1, 1'b0, 16'h0100, 16'hA75A);
    check("byte_neighbour", mem[16'h0101], 8'hC3);
    check("byte_mem", mem[16'h0100], 8'h5A);
    run_txn(1'b0, 1'b0, 16'h0100, 16'h0000);
    check("byte_rdata_const", rdata, 16'h005A);

    // word write then read
    run_txn(1'b1, 1'b1, 16'h2000, 16'hBEEF);
    check("word_mem0", mem[16'h2000], BIG ? 8'hBE : 8'hEF);
    check("word_mem1", mem[16'h2001], BIG ? 8'hEF : 8'hBE);
    run_txn(1'b0, 1'b1, 16'h2000, 16'h0000);
    check("word_rdata_const", rdata, 16'hBEEF);

    // address wrap
    run_txn(1'b1, 1'b1, 16'hFFFF, 16'h1234);
    check("wrap_ffff", mem[16'hFFFF], BIG ? 8'h12 : 8'h34);
    check("wrap_0000", mem[16'h0000], BIG ? 8'h34 : 8'h12);
    run_txn(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    check("wrap_rdata", rdata, 16'h1234);

    // fill a window, then randomized traffic inside it
    for (int i = 0; i < 16; i++)
      run_txn(1'b1, 1'b1, 16'h4000 + 16'(2 * i), 16'($urandom));
    for (int i = 0; i < 24; i++)
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'h4000 + 16'($urandom_range(0, 30)), 16'($urandom));

    // req held high with word reads; addr scrambled while busy
    req = 1'b1; we = 1'b0; word = 1'b1;
    last_ack = -1; n_ack = 0;
    for (int c = 0; c < 40; c++) begin
      if (ack) begin
        check("hold_rdata", rdata, exp_q.pop_front());
        if (last_ack >= 0) check("hold_spacing", 32'(c - last_ack), 32'd6);
        last_ack = c; n_ack++;
      end
      if (!busy && c < 34) begin
        addr = 16'h4000 + 16'($urandom_range(0, 30));
        exp_q.push_back(ref_read(addr, 1'b1));
      end else begin
        addr = 16'($urandom);
        if (!busy) req = 1'b0;
      end
      @(negedge clk);
    end
    req = 1'b0;
    check("hold_acks", 32'(n_ack), 32'd6);
    check("hold_q_empty", 32'(exp_q.size()), 32'd0);

    // reset during XFER_HI of a word write
    old_hi = ref_mem[16'h2001];
    req = 1'b1; we = 1'b1; word = 1'b1; addr = 16'h2000; wdata = 16'h1177;
    @(posedge clk);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) req = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst_gate_mem_we", mem_write_en, 1'b0);
    check("rst_gate_mar_we", mar_write_en, 1'b0);
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ack", ack, 1'b0);
    check("mid_rst_rdata", rdata, 16'h0000);
    check("mid_rst_bus", bus_out, BUS_IDLE);
    rst = 1'b0;
    ref_mem[16'h2000] = lane(16'h1177, 1'b1, 0);
    check("mid_rst_lo", mem[16'h2000], ref_mem[16'h2000]);
    check("mid_rst_hi", mem[16'h2001], old_hi);
    @(negedge clk);
    check("mid_rst_no_ack", ack, 1'b0);
    check("mid_rst_idle", busy, 1'b0);

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
